// File: rtl/nv_ram_pkg.sv
// Shared sizing and data types for the 160x16 read/write single-port RAM slice.
//   DEPTH      : number of entries
//   WIDTH      : data width
//   AW         : address width
//   ram_data_t : one RAM word
package nv_ram_pkg;

  localparam int unsigned DEPTH = 160;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 8;

  // Entry count in address width, for range comparisons without widening.
  localparam logic [AW-1:0] DEPTH_ADDR = AW'(DEPTH);

  typedef logic [WIDTH-1:0] ram_data_t;

endpackage

// File: rtl/nv_ram_array_160x16.sv
// Raw 160x16 storage: one synchronous write port and one asynchronous-index
// read port. Reset-free so it can map onto LUT RAM / block RAM.
// Ports:
//   clk     : write clock
//   we      : write enable (caller guarantees wa is in range)
//   wa, di  : write address / data
//   ra      : read index (caller masks out-of-range results)
//   rdata_c : combinational read data mem[ra]
module nv_ram_array_160x16
  import nv_ram_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  ram_data_t     di,
  input  logic [AW-1:0] ra,
  output ram_data_t     rdata_c
);

  ram_data_t mem_q [DEPTH];

  // Storage write; no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= di;
    end
  end

  assign rdata_c = mem_q[ra];

endmodule

// File: rtl/nv_ram_rwsp_160x16_core.sv
// 160x16 RAM with two-stage registered read: re fetches the array into rd_q,
// ore moves rd_q into the output register. Used under the SDP BRDMA command
// queue, which ties ore to its pop and re to its prefetch.
// Optional macro RAM_CONTENTION_CHECK_EN adds a simulation-only check for
// same-address write/fetch and out-of-range enabled addresses.
// Ports:
//   nvdla_core_clk_mgated : clock, rising edge
//   nvdla_core_rstn       : async active-low reset (clears rd_q and dout)
//   pwrbus_ram_pd         : RAM power-down bus, functionally ignored
//   wa, we, di            : write port
//   ra, re                : fetch port
//   ore                   : output-register enable
//   dout                  : registered read data
module nv_ram_rwsp_160x16_core
  import nv_ram_pkg::*;
#(
  parameter int unsigned FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 0
) (
  input  logic        nvdla_core_clk_mgated,
  input  logic        nvdla_core_rstn,
  input  logic [31:0] pwrbus_ram_pd,
  input  logic [7:0]  wa,
  input  logic        we,
  input  logic [15:0] di,
  input  logic [7:0]  ra,
  input  logic        re,
  input  logic        ore,
  output logic [15:0] dout
);

  ram_data_t rd_q,   rd_d;
  ram_data_t dout_q, dout_d;
  ram_data_t arr_rdata_c;
  logic      wa_ok_c;
  logic      ra_ok_c;
  logic      arr_we_c;
  logic      unused_c;

  assign wa_ok_c  = (wa < DEPTH_ADDR);
  assign ra_ok_c  = (ra < DEPTH_ADDR);
  assign arr_we_c = we & wa_ok_c;

  // Power bus and the check-disable parameter carry no datapath function.
  assign unused_c = ^{pwrbus_ram_pd, (FORCE_CONTENTION_ASSERTION_RESET_ACTIVE != 0)};

  nv_ram_array_160x16 u_array (
    .clk     (nvdla_core_clk_mgated),
    .we      (arr_we_c),
    .wa      (wa),
    .di      (di),
    .ra      (ra),
    .rdata_c (arr_rdata_c)
  );

  // Fetch and output stages; the array read sees pre-edge contents, giving
  // read-before-write on a same-address collision.
  always_comb begin
    rd_d   = rd_q;
    dout_d = dout_q;
    if (re) begin
      rd_d = ra_ok_c ? arr_rdata_c : '0;
    end
    if (ore) begin
      dout_d = rd_q;
    end
  end

  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef RAM_CONTENTION_CHECK_EN
  // Simulation-only hazard check.
  always_ff @(posedge nvdla_core_clk_mgated) begin
    if (nvdla_core_rstn) begin
      if ((FORCE_CONTENTION_ASSERTION_RESET_ACTIVE == 0) && we && re && (wa == ra)) begin
        $error("%m: same-address write/fetch contention at address %0d", wa);
      end
      if (we && !wa_ok_c) begin
        $error("%m: write address %0d out of range", wa);
      end
      if (re && !ra_ok_c) begin
        $error("%m: fetch address %0d out of range", ra);
      end
    end
  end
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_160x16_core.sv
// Self-checking bench for nv_ram_rwsp_160x16_core: directed scenarios plus a
// randomized run against a word-level reference model of the RAM.
module tb_nv_ram_rwsp_160x16_core;

  logic        clk;
  logic        rstn;
  logic [31:0] pwrbus_ram_pd;
  logic [7:0]  wa;
  logic        we;
  logic [15:0] di;
  logic [7:0]  ra;
  logic        re;
  logic        ore;
  logic [15:0] dout;

  int errors;
  int checks;

  // Reference model: memory contents, the fetched word, and the expected output.
  logic [15:0] m_mem [256];
  logic [15:0] m_rd;
  logic [15:0] m_dout;

  nv_ram_rwsp_160x16_core #(
    .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1)
  ) dut (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .pwrbus_ram_pd         (pwrbus_ram_pd),
    .wa                    (wa),
    .we                    (we),
    .di                    (di),
    .ra                    (ra),
    .re                    (re),
    .ore                   (ore),
    .dout                  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, clock it, advance the model, sample #1 later.
  task automatic step(input logic i_we, input logic [7:0] i_wa, input logic [15:0] i_di,
                      input logic i_re, input logic [7:0] i_ra, input logic i_ore);
    logic [15:0] old_rd;
    we = i_we; wa = i_wa; di = i_di;
    re = i_re; ra = i_ra; ore = i_ore;
    pwrbus_ram_pd = $urandom;
    @(posedge clk);
    old_rd = m_rd;
    if (i_re) m_rd = (i_ra < 8'd160) ? m_mem[i_ra] : 16'h0000;
    if (i_ore) m_dout = old_rd;
    if (i_we && (i_wa < 8'd160)) m_mem[i_wa] = i_di;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    we = 0; re = 0; ore = 0; wa = 0; ra = 0; di = 0; pwrbus_ram_pd = 0;
    m_rd = 16'h0; m_dout = 16'h0;
    #12;
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL reset_dout got=%h exp=0000", dout);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++;
      if (dout !== 16'h0000) begin
        errors++; $display("FAIL reset_hold[%0d] got=%h exp=0000", i, dout);
      end
    end
  endtask

  task automatic test_basic();
    step(1'b1, 8'd5, 16'hA5A5, 1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b1, 8'd5, 1'b0);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL basic_latency got=%h exp=0000", dout);
    end
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (dout !== 16'hA5A5) begin
      errors++; $display("FAIL basic_read got=%h exp=a5a5", dout);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (dout !== 16'hA5A5) begin
        errors++; $display("FAIL basic_hold[%0d] got=%h exp=a5a5", i, dout);
      end
    end
  endtask

  task automatic test_stream();
    for (int a = 0; a < 160; a++) step(1'b1, 8'(a), 16'(a * 3), 1'b0, 8'd0, 1'b0);
    // Out-of-range write must be dropped.
    step(1'b1, 8'd160, 16'hFFFF, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i <= 160; i++) begin
      step(1'b0, 8'd0, 16'h0, (i < 160), 8'(i), (i >= 1));
      if (i >= 1) begin
        checks++;
        if (dout !== 16'((i - 1) * 3)) begin
          errors++; $display("FAIL stream[%0d] got=%h exp=%h", i - 1, dout, 16'((i - 1) * 3));
        end
      end
    end
    step(1'b0, 8'd0, 16'h0, 1'b1, 8'd160, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL fetch_oob got=%h exp=0000", dout);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 8'd7, 16'h1111, 1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd7, 16'h2222, 1'b1, 8'd7, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (dout !== 16'h1111) begin
      errors++; $display("FAIL collision_old got=%h exp=1111", dout);
    end
    step(1'b0, 8'd0, 16'h0, 1'b1, 8'd7, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (dout !== 16'h2222) begin
      errors++; $display("FAIL collision_new got=%h exp=2222", dout);
    end
  endtask

  task automatic test_stall_reset();
    step(1'b1, 8'd1, 16'h0001, 1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b1, 8'd1, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (dout !== 16'h0001) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h exp=0001", i, dout);
      end
    end
    #2 rstn = 1'b0;
    m_rd = 16'h0; m_dout = 16'h0;
    #1;
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL async_reset got=%h exp=0000", dout);
    end
    @(negedge clk);
    rstn = 1'b1;
    // Rising ore alone after reset must not resurrect the pre-reset fetch.
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL reset_no_pending got=%h exp=0000", dout);
    end
    step(1'b0, 8'd0, 16'h0, 1'b1, 8'd1, 1'b0);
    step(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (dout !== 16'h0001) begin
      errors++; $display("FAIL array_kept got=%h exp=0001", dout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 170)), 16'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 170)), 1'($urandom_range(0, 1)));
      checks++;
      if (dout !== m_dout) begin
        errors++; $display("FAIL random[%0d] got=%h exp=%h", i, dout, m_dout);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
    test_reset();
    test_basic();
    test_stream();
    test_collision();
    test_stall_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
